// File: rtl/booth_mul_arbiter_pkg.sv
// Shared defaults and types for the Booth-multiplier sharing arbiter and its multiplier.
package booth_mul_pkg;

    localparam int N_DEF       = 8;
    localparam int NREQ_DEF    = 4;
    localparam int MUL_LAT_DEF = 2;
    localparam int ID_W        = $clog2(NREQ_DEF);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Request/response and multiplier-side bus of the shared Booth multiplier arbiter.
interface booth_mul_arbiter_if
    import booth_mul_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF
);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*N-1:0]        req_a;
    logic [NREQ*N-1:0]        req_b;
    logic signed [N-1:0]      mul_a;
    logic signed [N-1:0]      mul_b;
    logic signed [2*N-1:0]    mul_prod;
    logic [NREQ-1:0]          rsp_valid;
    logic signed [2*N-1:0]    rsp_prod;
    logic                     idle;

    modport slave (
        input  req_valid, req_a, req_b, mul_prod,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_prod, idle
    );

    modport master (
        output req_valid, req_a, req_b, mul_prod,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_prod, idle
    );

endinterface

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] gnt_id_o
);

    localparam int IDW = $clog2(NREQ);

    int             idx;
    logic [IDW-1:0] sel;
    logic           found;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = IDW'(idx);
            if (!found && req_i[sel]) begin
                found    = 1'b1;
                gnt_o    = '0;
                gnt_o[sel] = 1'b1;
                gnt_id_o = sel;
            end
        end
    end

endmodule

// File: rtl/radix4_booth_multiplier.sv
// Pipelined radix-4 Booth signed multiplier; product appears MUL_LAT cycles after operands.
module radix4_booth_multiplier
    import booth_mul_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                  clk,
    input  logic signed [N-1:0]   a_i,
    input  logic signed [N-1:0]   b_i,
    output logic signed [2*N-1:0] prod_o
);

    localparam int G  = (N + 1) / 2;
    localparam int BW = 2 * G;
    localparam int PW = 2 * N;

    // Recode b in overlapping 3-bit windows into digits {-2,-1,0,1,2}.
    function automatic logic signed [PW-1:0] booth(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
        logic signed [BW-1:0] bs;
        logic [BW:0]          bx;
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] pp;
        logic signed [PW-1:0] acc;
        bs  = BW'(b);
        bx  = {bs, 1'b0};
        ae  = PW'(a);
        acc = '0;
        for (int i = 0; i < G; i++) begin
            case (bx[2*i +: 3])
                3'b001, 3'b010: pp = ae;
                3'b011:         pp = ae <<< 1;
                3'b100:         pp = -(ae <<< 1);
                3'b101, 3'b110: pp = -ae;
                default:        pp = '0;
            endcase
            acc = acc + (pp <<< (2 * i));
        end
        return acc;
    endfunction

    logic signed [PW-1:0] prod_q [MUL_LAT];

    always_ff @(posedge clk) begin
        prod_q[0] <= booth(a_i, b_i);
        for (int k = 1; k < MUL_LAT; k++) begin
            prod_q[k] <= prod_q[k-1];
        end
    end

    assign prod_o = prod_q[MUL_LAT-1];

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one pipelined Booth multiplier; a tag pipeline routes each product home.
module booth_mul_arbiter
    import booth_mul_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    booth_mul_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } slot_t;

    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        gnt_id;
    logic                  xfer;
    logic signed [N-1:0]   a_sel, b_sel;

    logic [IDW-1:0]        ptr_q, ptr_d;
    logic signed [N-1:0]   mul_a_q, mul_a_d;
    logic signed [N-1:0]   mul_b_q, mul_b_d;
    slot_t                 tag_q [MUL_LAT+1];
    slot_t                 tag_d [MUL_LAT+1];
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic signed [2*N-1:0] rsp_prod_q, rsp_prod_d;
    logic                  idle_c;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i    (bus.req_valid),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    // Grant is suppressed while reset is held so nothing handshakes into a clearing pipeline.
    assign xfer          = !rst && (|gnt);
    assign bus.req_ready = rst ? '0 : gnt;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = bus.req_a[i*N +: N];
                b_sel = bus.req_b[i*N +: N];
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        tag_d[0] = '0;
        for (int k = 1; k <= MUL_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        if (xfer) begin
            ptr_d    = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
            mul_a_d  = a_sel;
            mul_b_d  = b_sel;
            tag_d[0] = '{valid: 1'b1, id: gnt_id};
        end
        // The last tag stage lines up with the multiplier output.
        rsp_valid_d = '0;
        rsp_prod_d  = rsp_prod_q;
        if (tag_q[MUL_LAT].valid) begin
            rsp_valid_d = NREQ'(1) << tag_q[MUL_LAT].id;
            rsp_prod_d  = bus.mul_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_prod_q  <= '0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_prod_q  <= rsp_prod_d;
            tag_q       <= tag_d;
        end
    end

    always_comb begin
        idle_c = (rsp_valid_q == '0);
        for (int k = 0; k <= MUL_LAT; k++) begin
            if (tag_q[k].valid) idle_c = 1'b0;
        end
    end

    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign bus.idle      = idle_c;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed scoreboard bench for booth_mul_arbiter wired to a radix4_booth_multiplier.
module tb_booth_mul_arbiter;
    import booth_mul_pkg::*;

    localparam int N       = N_DEF;
    localparam int NREQ    = NREQ_DEF;
    localparam int MUL_LAT = MUL_LAT_DEF;
    localparam int IDW     = $clog2(NREQ);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mul_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    booth_mul_arbiter #(.N(N), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    radix4_booth_multiplier #(.N(N), .MUL_LAT(MUL_LAT)) u_mul (
        .clk    (clk),
        .a_i    (bus.mul_a),
        .b_i    (bus.mul_b),
        .prod_o (bus.mul_prod)
    );

    typedef struct {
        logic [IDW-1:0]        id;
        logic signed [2*N-1:0] prod;
        int                    due;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;
    int   cyc  = 0;
    logic final_chk = 1'b0;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic setop(input int i, input int a, input int b);
        bus.req_a[i*N +: N] = N'(a);
        bus.req_b[i*N +: N] = N'(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: round-robin pointer, expected grant, and response scoreboard.
    initial begin
        logic [IDW-1:0]        mptr;
        logic                  prev_rst;
        logic [NREQ-1:0]       eg, ev;
        logic                  hit;
        logic [IDW-1:0]        gi, j;
        logic signed [N-1:0]   ma, mb;
        logic signed [2*N-1:0] ea, eb;
        exp_t                  e;
        mptr     = '0;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_rst) begin
                chk("rst_mul_a", 64'(bus.mul_a), 64'sd0);
                chk("rst_mul_b", 64'(bus.mul_b), 64'sd0);
                chk("rst_rsp_prod", 64'(bus.rsp_prod), 64'sd0);
            end
            eg  = '0;
            hit = 1'b0;
            gi  = '0;
            for (int k = 0; k < NREQ; k++) begin
                j = IDW'((int'(mptr) + k) % NREQ);
                if (!rst && !hit && bus.req_valid[j]) begin
                    hit = 1'b1;
                    gi  = j;
                end
            end
            if (hit) eg[gi] = 1'b1;
            chk("req_ready", 64'(bus.req_ready), 64'(eg));
            chk("idle", 64'(bus.idle), 64'(sb.size() == 0));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e  = sb.pop_front();
                ev = '0;
                ev[e.id] = 1'b1;
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
                chk("rsp_prod", 64'(bus.rsp_prod), 64'(e.prod));
            end else begin
                chk("rsp_valid_quiet", 64'(bus.rsp_valid), 64'sd0);
            end
            if (rst) begin
                sb.delete();
                mptr = '0;
            end else if (hit) begin
                ma = N'(bus.req_a >> (int'(gi) * N));
                mb = N'(bus.req_b >> (int'(gi) * N));
                ea = (2*N)'(ma);
                eb = (2*N)'(mb);
                e.id   = gi;
                e.prod = ea * eb;
                e.due  = cyc + MUL_LAT + 2;
                sb.push_back(e);
                mptr = (int'(gi) == NREQ - 1) ? '0 : gi + 1'b1;
            end
            if (final_chk) chk("drained", 64'(sb.size()), 64'sd0);
            prev_rst = rst;
        end
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        setop(0, 7, -2);
        setop(1, -5, -3);
        setop(2, 127, 127);
        setop(3, -128, -1);
        bus.req_valid = '1;
        tick(3);
        rst = 1'b0;
        tick(8);
        bus.req_valid = '0;
        tick(6);

        setop(2, -6, 4);
        bus.req_valid = 4'b0100;
        tick(1);
        bus.req_valid = '0;
        tick(6);

        setop(0, 3, 5);
        bus.req_valid = 4'b0001;
        tick(1);
        setop(1, -1, -1);
        bus.req_valid = 4'b0010;
        tick(1);
        setop(1, -100, 3);
        setop(3, 55, -77);
        bus.req_valid = 4'b1010;
        tick(1);
        bus.req_valid = 4'b0010;
        tick(1);
        bus.req_valid = '0;
        tick(6);

        setop(0, 0, 15);
        bus.req_valid = 4'b0001;
        tick(1);
        setop(0, 0, 0);
        tick(1);
        bus.req_valid = '0;
        tick(6);

        setop(0, 11, -9);
        bus.req_valid = 4'b0001;
        tick(1);
        setop(1, -7, 13);
        bus.req_valid = 4'b0010;
        tick(1);
        setop(2, 100, -100);
        bus.req_valid = 4'b0100;
        tick(1);
        bus.req_valid = '0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        setop(1, 7, -2);
        bus.req_valid = 4'b0010;
        tick(1);
        bus.req_valid = '0;
        tick(6);

        final_chk = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
